// File: rtl/lamp_ctrl_pkg.sv
// Shared definitions for the lamp-controller blocks.
// Holds the decoder timing constants that the push-button driver's parameter
// bounds are checked against, and the driver's FSM state type.
package lamp_ctrl_pkg;

  // Decoder thresholds (cycles): a press must exceed DEBOUNCE_P to register,
  // and must exceed SWITCH_MODE_MIN_T to be taken as a mode switch.
  localparam int DEBOUNCE_P        = 300;
  localparam int SWITCH_MODE_MIN_T = 5000;
  localparam int AUTO_SHUTDOWN_T   = 30000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRESS = 2'd1,
    GAP   = 2'd2
  } pbd_state_t;

endpackage

// File: rtl/push_button_driver_if.sv
// Command/button bundle for push_button_driver.
// master: command source (supervisor or bench); slave: the driver.
//   cmd_valid/cmd_long/cancel  source -> driver
//   cmd_ready/push_button/busy/done/dbg_state  driver -> source
// Handshake: a command transfers on a posedge where cmd_valid && cmd_ready;
// cmd_long is sampled on that edge. cmd_valid seen while cmd_ready is low is
// not stored; the source keeps it asserted until it is taken.
interface push_button_driver_if;
  import lamp_ctrl_pkg::*;

  logic       cmd_valid;
  logic       cmd_long;
  logic       cmd_ready;
  logic       cancel;
  logic       push_button;
  logic       busy;
  logic       done;
  pbd_state_t dbg_state;

  modport master (
    output cmd_valid, cmd_long, cancel,
    input  cmd_ready, push_button, busy, done, dbg_state
  );

  modport slave (
    input  cmd_valid, cmd_long, cancel,
    output cmd_ready, push_button, busy, done, dbg_state
  );

endinterface

// File: rtl/push_button_driver_interval_timer.sv
// interval_timer: up-counter with synchronous clear and a terminal-count compare.
//   clk, rst  clock and synchronous active-high reset
//   clear     zero the count (wins over enable)
//   enable    advance the count by one this cycle
//   terminal  compare value
//   expire    count == terminal (combinational)
// The owner must clear or stop the timer on expire; the count never wraps
// in normal use because the terminal compare ends each interval first.
module interval_timer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             enable,
  input  logic [CNT_W-1:0] terminal,
  output logic             expire
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + CNT_W'(1);
    end
  end

  assign expire = (count == terminal);

endmodule

// File: rtl/push_button_driver.sv
// push_button_driver: turns one-shot commands into timed push_button presses.
//   clk, rst  clock and synchronous active-high reset
//   bus       push_button_driver_if.slave:
//               cmd_valid/cmd_long in, cmd_ready out (command handshake)
//               cancel in (abort the press in progress)
//               push_button out (registered button line)
//               busy out (press or gap running), done out (1-cycle end pulse)
//               dbg_state out (current FSM state)
// A short command holds the line high SHORT_PRESS_T cycles, a long one
// LONG_PRESS_T cycles; every press is followed by RELEASE_GAP_T low cycles.
module push_button_driver
  import lamp_ctrl_pkg::*;
#(
  parameter int SHORT_PRESS_T = 1000,
  parameter int LONG_PRESS_T  = 6000,
  parameter int RELEASE_GAP_T = 500,
  parameter int CNT_W         = 16
) (
  input logic                 clk,
  input logic                 rst,
  push_button_driver_if.slave bus
);

  if (SHORT_PRESS_T <= DEBOUNCE_P || SHORT_PRESS_T >= SWITCH_MODE_MIN_T) begin : g_bad_short
    $error("push_button_driver: SHORT_PRESS_T out of range");
  end
  if (LONG_PRESS_T <= SWITCH_MODE_MIN_T) begin : g_bad_long
    $error("push_button_driver: LONG_PRESS_T too small");
  end
  if (RELEASE_GAP_T < 2) begin : g_bad_gap
    $error("push_button_driver: RELEASE_GAP_T too small");
  end
  if (((LONG_PRESS_T - 1) >> CNT_W) != 0 || ((RELEASE_GAP_T - 1) >> CNT_W) != 0) begin : g_bad_w
    $error("push_button_driver: CNT_W too narrow");
  end

  localparam logic [CNT_W-1:0] SHORT_TC = CNT_W'(SHORT_PRESS_T - 1);
  localparam logic [CNT_W-1:0] LONG_TC  = CNT_W'(LONG_PRESS_T - 1);
  localparam logic [CNT_W-1:0] GAP_TC   = CNT_W'(RELEASE_GAP_T - 1);

  pbd_state_t       state_q, state_d;
  logic             len_q, len_d;
  logic             pb_q;
  logic             done_q, done_d;
  logic             accept;
  logic             ready;
  logic             tmr_clear;
  logic             tmr_en;
  logic [CNT_W-1:0] terminal;
  logic             expire;

  // Ready is gated by rst so nothing is accepted on a reset edge.
  assign ready    = (state_q == IDLE) && !rst;
  assign accept   = bus.cmd_valid && ready;
  assign tmr_en   = (state_q != IDLE);
  assign terminal = (state_q == PRESS) ? (len_q ? LONG_TC : SHORT_TC) : GAP_TC;

  interval_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .clear    (tmr_clear),
    .enable   (tmr_en),
    .terminal (terminal),
    .expire   (expire)
  );

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    tmr_clear = 1'b0;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        // Holding the timer at zero in IDLE makes every interval start from 0.
        tmr_clear = 1'b1;
        if (accept) begin
          state_d = PRESS;
          len_d   = bus.cmd_long;
        end
      end
      PRESS: begin
        if (bus.cancel || expire) begin
          state_d   = GAP;
          tmr_clear = 1'b1;
        end
      end
      GAP: begin
        if (expire) begin
          state_d   = IDLE;
          tmr_clear = 1'b1;
          done_d    = 1'b1;
        end
      end
      default: begin
        state_d   = IDLE;
        tmr_clear = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      len_q   <= 1'b0;
      pb_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      pb_q    <= (state_d == PRESS);
      done_q  <= done_d;
    end
  end

  assign bus.cmd_ready   = ready;
  assign bus.push_button = pb_q;
  assign bus.busy        = (state_q != IDLE);
  assign bus.done        = done_q;
  assign bus.dbg_state   = state_q;

endmodule
